// File: rtl/uart_word_xcvr_if.sv
// Word-level bus of uart_word_xcvr: TX handshake, both serial lines and RX status.
// The slave modport is the transceiver's view; the master modport is the host's view.
interface uart_word_xcvr_if #(
  parameter int DATA_W = 32
);
  logic              Tx_Start;
  logic [DATA_W-1:0] Data_Tx;
  logic              Tx_Busy;
  logic              OUT_ser;
  logic              Rx;
  logic              CLR_Rx;
  logic [DATA_W-1:0] Data_Rx;
  logic              Data_Ready;
  logic              Parity_ERR;
  logic              Framing_ERR;
  logic              Overrun_ERR;

  modport master (
    output Tx_Start, Data_Tx, Rx, CLR_Rx,
    input  Tx_Busy, OUT_ser, Data_Rx, Data_Ready, Parity_ERR, Framing_ERR, Overrun_ERR
  );

  modport slave (
    input  Tx_Start, Data_Tx, Rx, CLR_Rx,
    output Tx_Busy, OUT_ser, Data_Rx, Data_Ready, Parity_ERR, Framing_ERR, Overrun_ERR
  );
endinterface

// File: rtl/uart_word_xcvr.sv
// Full-duplex UART carrying one DATA_W-bit word per frame, LSB first.
// Define UART_PARITY_EN to send and check a parity bit of sense PARITY_ODD.
//
// state     | meaning
// TX_IDLE   | line high, accepts Tx_Start
// TX_START  | start bit
// TX_DATA   | payload bits from the shift register
// TX_PARITY | parity bit
// TX_STOP   | STOP_BITS stop bits
// RX_ARM    | wait for a high line before hunting for starts
// RX_IDLE   | wait for a low line
// RX_START  | re-check the start bit at half a bit
// RX_DATA   | sample payload mid-bit
// RX_PARITY | sample parity mid-bit
// RX_STOP   | sample stop bits mid-bit, deliver the word on the last one
module uart_word_xcvr #(
  parameter int DATA_W       = 32,
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input logic             CLK,
  input logic             RST,
  uart_word_xcvr_if.slave bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic             ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_ARM, RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

  tx_state_e         tx_state_q, tx_state_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]  tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              tx_par_q, tx_par_d;

  rx_state_e         rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0]  rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic              rx_pbit_q, rx_pbit_d;
  logic              rx_fbad_q, rx_fbad_d;
  logic              rx_meta_q, rx_sync_q;
  logic [DATA_W:0]   rx_cat;
  logic              rx_done;

  logic [DATA_W-1:0] data_rx_q, data_rx_d;
  logic              ready_q, ready_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    if (tx_state_q == TX_IDLE) begin
      if (bus.Tx_Start) begin
        tx_state_d = TX_START;
        tx_cnt_d   = BIT_LAST;
        tx_shift_d = bus.Data_Tx;
        tx_par_d   = (^bus.Data_Tx) ^ ODD;
      end
    end else if (tx_cnt_q != '0) begin
      tx_cnt_d = tx_cnt_q - CNT_W'(1);
    end else begin
      tx_cnt_d = BIT_LAST;
      case (tx_state_q)
        TX_START: begin
          tx_state_d = TX_DATA;
          tx_bit_d   = DATA_LAST;
        end
        TX_DATA: begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q != '0) begin
            tx_bit_d = tx_bit_q - BIT_W'(1);
          end else begin
`ifdef UART_PARITY_EN
            tx_state_d = TX_PARITY;
`else
            tx_state_d = TX_STOP;
`endif
            tx_bit_d = STOP_LAST;
          end
        end
        TX_PARITY: tx_state_d = TX_STOP;
        TX_STOP: begin
          if (tx_bit_q != '0) tx_bit_d = tx_bit_q - BIT_W'(1);
          else tx_state_d = TX_IDLE;
        end
        default: tx_state_d = TX_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.Tx_Busy = (tx_state_q != TX_IDLE);
    case (tx_state_q)
      TX_START:  bus.OUT_ser = 1'b0;
      TX_DATA:   bus.OUT_ser = tx_shift_q[0];
      TX_PARITY: bus.OUT_ser = tx_par_q;
      default:   bus.OUT_ser = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RX_ARM;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_pbit_q  <= 1'b0;
      rx_fbad_q  <= 1'b0;
      data_rx_q  <= '0;
      ready_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_meta_q  <= bus.Rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_pbit_q  <= rx_pbit_d;
      rx_fbad_q  <= rx_fbad_d;
      data_rx_q  <= data_rx_d;
      ready_q    <= ready_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_cat = {rx_sync_q, rx_shift_q};

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_pbit_d  = rx_pbit_q;
    rx_fbad_d  = rx_fbad_q;
    case (rx_state_q)
      RX_ARM: if (rx_sync_q) rx_state_d = RX_IDLE;
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = HALF_LAST;
        end
      end
      default: begin
        if (rx_cnt_q != '0) begin
          rx_cnt_d = rx_cnt_q - CNT_W'(1);
        end else begin
          rx_cnt_d = BIT_LAST;
          case (rx_state_q)
            RX_START: begin
              // a start bit that is gone by mid-bit was a glitch
              if (rx_sync_q) begin
                rx_state_d = RX_IDLE;
              end else begin
                rx_state_d = RX_DATA;
                rx_bit_d   = DATA_LAST;
              end
            end
            RX_DATA: begin
              rx_shift_d = rx_cat[DATA_W:1];
              if (rx_bit_q != '0) begin
                rx_bit_d = rx_bit_q - BIT_W'(1);
              end else begin
`ifdef UART_PARITY_EN
                rx_state_d = RX_PARITY;
`else
                rx_state_d = RX_STOP;
`endif
                rx_bit_d  = STOP_LAST;
                rx_fbad_d = 1'b0;
              end
            end
            RX_PARITY: begin
              rx_pbit_d  = rx_sync_q;
              rx_state_d = RX_STOP;
            end
            RX_STOP: begin
              rx_fbad_d = rx_fbad_q | ~rx_sync_q;
              if (rx_bit_q != '0) rx_bit_d = rx_bit_q - BIT_W'(1);
              else rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_ARM;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    rx_done   = (rx_state_q == RX_STOP) && (rx_cnt_q == '0) && (rx_bit_q == '0);
    data_rx_d = rx_done ? rx_shift_q : data_rx_q;
    ready_d   = rx_done | (ready_q & ~bus.CLR_Rx);
    // an acknowledge landing with a new word retires the old one, so no overrun
    ovr_d     = rx_done ? (ready_q & ~bus.CLR_Rx) : (ovr_q & ~bus.CLR_Rx);
    ferr_d    = rx_done ? (rx_fbad_q | ~rx_sync_q) : ferr_q;
`ifdef UART_PARITY_EN
    perr_d    = rx_done ? ((^rx_shift_q) ^ rx_pbit_q ^ ODD) : perr_q;
`else
    perr_d    = 1'b0;
`endif
  end

`ifndef UART_PARITY_EN
  logic unused_pbit;
  assign unused_pbit = rx_pbit_q;
`endif

  assign bus.Data_Rx     = data_rx_q;
  assign bus.Data_Ready  = ready_q;
  assign bus.Parity_ERR  = perr_q;
  assign bus.Framing_ERR = ferr_q;
  assign bus.Overrun_ERR = ovr_q;

endmodule

// File: tb/tb_uart_word_xcvr.sv
// Bench for uart_word_xcvr: 32-bit words, 8 clocks per bit, even parity when UART_PARITY_EN.
module tb_uart_word_xcvr;

  localparam int CPB = 8;
`ifdef UART_PARITY_EN
  localparam bit PEN         = 1'b1;
  localparam int EXP_BUSY    = 280;
  localparam bit EXP_PAR_BAD = 1'b1;
`else
  localparam bit PEN         = 1'b0;
  localparam int EXP_BUSY    = 272;
  localparam bit EXP_PAR_BAD = 1'b0;
`endif
  localparam int NBITS = 34 + int'(PEN);
  localparam int LEN   = NBITS * CPB;

  logic clk = 1'b0;
  logic rst;
  logic loop;
  logic rx_drv;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  uart_word_xcvr_if #(.DATA_W(32)) bus ();

  assign bus.Rx = loop ? bus.OUT_ser : rx_drv;

  uart_word_xcvr #(
    .DATA_W(32), .CLKS_PER_BIT(CPB), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut (
    .CLK(clk), .RST(rst), .bus(bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Serial level of frame bit idx: start, data LSB first, optional parity, stop.
  function automatic logic frame_bit(input logic [31:0] w, input int idx, input logic pb,
                                     input logic sb);
    if (idx == 0) return 1'b0;
    if (idx <= 32) return w[idx-1];
    if (PEN && idx == 33) return pb;
    return sb;
  endfunction

  // TX model: which frame bit must be on the line, cycle by cycle.
  logic        m_active = 1'b0;
  int          m_k = 0;
  logic [31:0] m_word = '0;

  always @(posedge clk) begin
    if (rst) m_active <= 1'b0;
    else if (!m_active) begin
      if (bus.Tx_Start) begin
        m_active <= 1'b1;
        m_k      <= 0;
        m_word   <= bus.Data_Tx;
      end
    end else if (m_k == LEN - 1) m_active <= 1'b0;
    else m_k <= m_k + 1;
  end

  // RX model: status registers as they must read once the line is quiet.
  logic        chk_en, rx_quiet;
  logic [31:0] exp_data;
  logic        exp_ready, exp_perr, exp_ferr, exp_ovr;

  function automatic void apply_frame(input logic [31:0] w, input logic perr, input logic ferr);
    exp_ovr   = exp_ready;
    exp_ready = 1'b1;
    exp_data  = w;
    exp_perr  = perr;
    exp_ferr  = ferr;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("OUT_ser", bus.OUT_ser,
            m_active ? frame_bit(m_word, m_k / CPB, ^m_word, 1'b1) : 1'b1);
      check("Tx_Busy", bus.Tx_Busy, m_active);
      if (rx_quiet) begin
        check("Data_Rx", bus.Data_Rx, exp_data);
        check("Data_Ready", bus.Data_Ready, exp_ready);
        check("Parity_ERR", bus.Parity_ERR, exp_perr);
        check("Framing_ERR", bus.Framing_ERR, exp_ferr);
        check("Overrun_ERR", bus.Overrun_ERR, exp_ovr);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Starts a frame and returns once Tx_Busy has fallen (in that same cycle).
  task automatic tx_word(input logic [31:0] w, output int busy_cycles);
    bus.Tx_Start = 1'b1;
    bus.Data_Tx  = w;
    idle(1);
    bus.Tx_Start = 1'b0;
    bus.Data_Tx  = ~w;
    busy_cycles  = 0;
    for (int i = 0; i < LEN + 50 && bus.Tx_Busy; i++) begin
      busy_cycles++;
      idle(1);
    end
    check("tx_busy_end", bus.Tx_Busy, 1'b0);
  endtask

  task automatic send_raw(input logic [31:0] w, input logic pb, input logic sb);
    for (int i = 0; i < NBITS; i++) begin
      rx_drv = frame_bit(w, i, pb, sb);
      idle(CPB);
    end
    rx_drv = 1'b1;
  endtask

  task automatic clr();
    bus.CLR_Rx = 1'b1;
    idle(1);
    bus.CLR_Rx = 1'b0;
    exp_ready  = 1'b0;
    exp_ovr    = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.Tx_Start = 1'b0;
    bus.Data_Tx  = '0;
    bus.CLR_Rx   = 1'b0;
    loop = 1'b1;
    rx_drv = 1'b1;
    chk_en = 1'b0;
    rx_quiet = 1'b0;
    exp_data = '0;
    exp_ready = 1'b0;
    exp_perr = 1'b0;
    exp_ferr = 1'b0;
    exp_ovr = 1'b0;

    idle(1);
    rst = 1'b0;
    chk_en = 1'b1;
    rx_quiet = 1'b1;
    check("rst_OUT_ser", bus.OUT_ser, 1'b1);
    check("rst_Tx_Busy", bus.Tx_Busy, 1'b0);
    check("rst_Data_Ready", bus.Data_Ready, 1'b0);
    check("rst_Data_Rx", bus.Data_Rx, 32'h0);
    check("rst_errs", {bus.Parity_ERR, bus.Framing_ERR, bus.Overrun_ERR}, 3'b000);
    idle(20);

    // loopback of a single word
    rx_quiet = 1'b0;
    apply_frame(32'h0000_0001, 1'b0, 1'b0);
    tx_word(32'h0000_0001, n);
    check("busy_len", n, EXP_BUSY);
    idle(4);
    rx_quiet = 1'b1;
    check("loop_Data_Rx", bus.Data_Rx, 32'h0000_0001);
    check("loop_Data_Ready", bus.Data_Ready, 1'b1);
    check("loop_errs", {bus.Parity_ERR, bus.Framing_ERR}, 2'b00);
    clr();

    // wrong parity bit driven directly
    loop = 1'b0;
    rx_quiet = 1'b0;
    apply_frame(32'hA5A5_A5A5, PEN & ((^32'hA5A5_A5A5) ^ 1'b1), 1'b0);
    send_raw(32'hA5A5_A5A5, 1'b1, 1'b1);
    idle(4);
    rx_quiet = 1'b1;
    check("par_Data_Rx", bus.Data_Rx, 32'hA5A5_A5A5);
    check("par_Parity_ERR", bus.Parity_ERR, EXP_PAR_BAD);
    loop = 1'b1;
    rx_quiet = 1'b0;
    apply_frame(32'h0000_0003, 1'b0, 1'b0);
    tx_word(32'h0000_0003, n);
    idle(4);
    rx_quiet = 1'b1;
    check("par_ok_Parity_ERR", bus.Parity_ERR, 1'b0);
    check("par_ok_Data_Rx", bus.Data_Rx, 32'h0000_0003);
    clr();

    // low stop bit; the error survives an acknowledge
    loop = 1'b0;
    rx_quiet = 1'b0;
    apply_frame(32'h1234_5678, 1'b0, 1'b1);
    send_raw(32'h1234_5678, ^32'h1234_5678, 1'b0);
    idle(20);
    rx_quiet = 1'b1;
    check("frm_Framing_ERR", bus.Framing_ERR, 1'b1);
    check("frm_Data_Ready", bus.Data_Ready, 1'b1);
    check("frm_Data_Rx", bus.Data_Rx, 32'h1234_5678);
    clr();
    check("frm_kept_by_clr", bus.Framing_ERR, 1'b1);

    // overrun with back-to-back transmit
    loop = 1'b1;
    rx_quiet = 1'b0;
    apply_frame(32'h11, 1'b0, 1'b0);
    tx_word(32'h11, n);
    apply_frame(32'h22, 1'b0, 1'b0);
    tx_word(32'h22, n);
    idle(4);
    rx_quiet = 1'b1;
    check("ovr_Overrun_ERR", bus.Overrun_ERR, 1'b1);
    check("ovr_Data_Rx", bus.Data_Rx, 32'h22);
    clr();
    check("ovr_clr_Data_Ready", bus.Data_Ready, 1'b0);
    check("ovr_clr_Overrun_ERR", bus.Overrun_ERR, 1'b0);

    // two-cycle glitch on the line
    loop = 1'b0;
    rx_drv = 1'b0;
    idle(2);
    rx_drv = 1'b1;
    idle(40);
    check("glitch_Data_Ready", bus.Data_Ready, 1'b0);

    // reset 100 cycles into a frame
    loop = 1'b1;
    rx_quiet = 1'b0;
    bus.Tx_Start = 1'b1;
    bus.Data_Tx  = 32'h5A5A_0FF0;
    idle(1);
    bus.Tx_Start = 1'b0;
    idle(99);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    exp_data = '0;
    exp_ready = 1'b0;
    exp_perr = 1'b0;
    exp_ferr = 1'b0;
    exp_ovr = 1'b0;
    rx_quiet = 1'b1;
    check("abort_OUT_ser", bus.OUT_ser, 1'b1);
    check("abort_Tx_Busy", bus.Tx_Busy, 1'b0);
    idle(400);
    check("abort_Data_Ready", bus.Data_Ready, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
